// File: rtl/mem_bank_ctrl.sv
// Purpose: single-port access controller that shares one mem_bank between a write and a read requester.
// Latency: a write commits at the end of its grant cycle; read response valid 2 cycles after the read handshake.
// Backpressure: a pending unconsumed response blocks new read grants; writes keep flowing meanwhile.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   wr_valid/wr_ready, wr_row,
//   wr_data, wr_strb                write request channel (one line, per-byte strobes)
//   rd_valid/rd_ready, rd_row       read request channel
//   rsp_valid/rsp_ready, rsp_data   read response channel (holding register)
//   bank_we, bank_row, bank_wdata,
//   bank_wstrb, bank_rdata          mem_bank interface (rdata is registered, 1-cycle)
module mem_bank_ctrl #(
  parameter  int SIZE = 7,
  localparam int RW   = 12 - SIZE,
  localparam int LB   = 2**SIZE,
  localparam int DW   = 8 * LB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [RW-1:0] wr_row,
  input  logic [DW-1:0] wr_data,
  input  logic [LB-1:0] wr_strb,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [RW-1:0] rd_row,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          bank_we,
  output logic [RW-1:0] bank_row,
  output logic [DW-1:0] bank_wdata,
  output logic [LB-1:0] bank_wstrb,
  input  logic [DW-1:0] bank_rdata
);

  localparam logic GNT_WR = 1'b0;
  localparam logic GNT_RD = 1'b1;

  logic          last_gnt_q, last_gnt_d;
  logic          rd_inflight_q, rd_inflight_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  logic wr_elig, rd_elig;
  logic gnt_wr, gnt_rd;

  always_comb begin
    wr_elig = wr_valid;
    // A read may only issue when the holding register is free by the time
    // its data lands, and never back-to-back with the previous read.
    rd_elig = rd_valid && !rd_inflight_q && (!rsp_valid_q || rsp_ready);

    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    if (!rst) begin
      if (wr_elig && rd_elig) begin
        gnt_wr = (last_gnt_q == GNT_RD);
        gnt_rd = (last_gnt_q == GNT_WR);
      end else begin
        gnt_wr = wr_elig;
        gnt_rd = rd_elig;
      end
    end

    last_gnt_d = last_gnt_q;
    if (gnt_wr) begin
      last_gnt_d = GNT_WR;
    end else if (gnt_rd) begin
      last_gnt_d = GNT_RD;
    end

    rd_inflight_d = gnt_rd;

    // Capture of fresh bank data takes priority over the consume-clear.
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (rd_inflight_q) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = bank_rdata;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q    <= GNT_RD;
      rd_inflight_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      last_gnt_q    <= last_gnt_d;
      rd_inflight_q <= rd_inflight_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  assign wr_ready   = gnt_wr;
  assign rd_ready   = gnt_rd;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;

  // The bank writes on strobes alone, so strobes are zeroed on every
  // cycle that is not a granted write (reset included via gnt_wr).
  assign bank_we    = gnt_wr;
  assign bank_wstrb = gnt_wr ? wr_strb : '0;
  assign bank_row   = gnt_wr ? wr_row : rd_row;
  assign bank_wdata = wr_data;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Purpose: self-checking bench for mem_bank_ctrl with a behavioural bank and a transaction-level reference model.
// Latency: n/a (bench).
// Backpressure: rsp_ready is driven randomly and by directed tables.
module tb_mem_bank_ctrl;
  localparam int SIZE  = 7;
  localparam int RW    = 12 - SIZE;
  localparam int LB    = 2**SIZE;
  localparam int DW    = 8 * LB;
  localparam int NROWS = 2**RW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_ready;
  logic [RW-1:0] wr_row;
  logic [DW-1:0] wr_data;
  logic [LB-1:0] wr_strb;
  logic          rd_valid, rd_ready;
  logic [RW-1:0] rd_row;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          bank_we;
  logic [RW-1:0] bank_row;
  logic [DW-1:0] bank_wdata;
  logic [LB-1:0] bank_wstrb;
  logic [DW-1:0] bank_rdata;

  mem_bank_ctrl #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_row(rd_row),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .bank_we(bank_we), .bank_row(bank_row), .bank_wdata(bank_wdata),
    .bank_wstrb(bank_wstrb), .bank_rdata(bank_rdata)
  );

  initial forever #5 clk = ~clk;

  // Behavioural storage bank: byte-strobed write, registered read of the addressed row.
  logic [DW-1:0] bank_mem [NROWS];
  always @(posedge clk) begin
    for (int b = 0; b < LB; b++)
      if (bank_wstrb[b]) bank_mem[bank_row][b*8 +: 8] <= bank_wdata[b*8 +: 8];
    bank_rdata <= bank_mem[bank_row];
  end

  // Reference model: memory image, queue of responses with their visibility time,
  // time of the last read grant and which side wins the next contention.
  typedef struct { logic [DW-1:0] d; int t; } rsp_t;
  logic [DW-1:0] mem_m [NROWS];
  rsp_t          rsp_q [$];
  int            now = 0;
  int            last_rd_t = -10;
  bit            prefer_rd = 1'b0;
  bit            model_ok = 1'b0;

  int nchk = 0;
  int nerr = 0;

  // Values seen by the most recent step, for directed checks.
  logic          s_wr, s_rd, s_rv;
  logic [DW-1:0] s_dat;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, now, act, exp);
    end
  endtask

  task automatic chk_dat(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    int first;
    nchk++;
    if (act !== exp) begin
      nerr++;
      first = -1;
      for (int b = LB - 1; b >= 0; b--)
        if (act[b*8 +: 8] !== exp[b*8 +: 8]) first = b;
      $display("FAIL %s @cyc %0d: byte %0d got %h expected %h (low words got %h expected %h)",
               nm, now, first, act[first*8 +: 8], exp[first*8 +: 8], act[63:0], exp[63:0]);
    end
  endtask

  // One clock cycle: inputs already applied; check outputs, then advance model.
  task automatic step();
    bit vis, rel, gw, gr;
    logic [DW-1:0] hd;
    #1;
    vis = (rsp_q.size() > 0) && (rsp_q[0].t <= now);
    hd  = vis ? rsp_q[0].d : '0;
    rel = rd_valid && ((now - last_rd_t) >= 2) && !(vis && !rsp_ready);
    if (rst) begin
      gw = 1'b0; gr = 1'b0;
    end else if (wr_valid && rel) begin
      gw = !prefer_rd; gr = prefer_rd;
    end else begin
      gw = wr_valid; gr = rel;
    end
    s_wr = wr_ready; s_rd = rd_ready; s_rv = rsp_valid; s_dat = rsp_data;
    chk("wr_ready", wr_ready, gw);
    chk("rd_ready", rd_ready, gr);
    chk("bank_we", bank_we, gw);
    chk("bank_wstrb", bank_wstrb, gw ? wr_strb : '0);
    if (gw) chk("bank_row_wr", bank_row, wr_row);
    else    chk("bank_row_rd", bank_row, rd_row);
    chk_dat("bank_wdata", bank_wdata, wr_data);
    if (model_ok) begin
      chk("rsp_valid", rsp_valid, vis);
      if (vis) chk_dat("rsp_data", rsp_data, hd);
    end
    @(posedge clk);
    if (rst) begin
      rsp_q.delete();
      last_rd_t = -10;
      prefer_rd = 1'b0;
      model_ok  = 1'b1;
    end else begin
      if (vis && rsp_ready) rsp_q.delete(0);
      if (gw) begin
        for (int b = 0; b < LB; b++)
          if (wr_strb[b]) mem_m[wr_row][b*8 +: 8] = wr_data[b*8 +: 8];
        prefer_rd = 1'b1;
      end
      if (gr) begin
        rsp_q.push_back('{d: mem_m[rd_row], t: now + 2});
        last_rd_t = now;
        prefer_rd = 1'b0;
      end
    end
    now++;
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [LB-1:0] rand_strb();
    logic [LB-1:0] v;
    for (int i = 0; i < LB/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  typedef struct {
    bit wv, rv, rr;
    bit e_wr, e_rd, e_rv;
  } vec_t;
  vec_t tbl [14];

  logic [DW-1:0] pat_a5, pat_part, prev_dat;
  bit            prev_rv, prev_rr;

  initial begin
    // Contention from reset release, then 5 cycles of response backpressure.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int b = 0; b < LB; b++) begin
      pat_a5[b*8 +: 8]   = 8'hA5;
      pat_part[b*8 +: 8] = (b < 4) ? 8'hFF : 8'h11;
    end

    // Reset with an aggressive write request pending.
    rst = 1'b1; wr_valid = 1'b1; wr_row = '0; wr_data = '1; wr_strb = '1;
    rd_valid = 1'b0; rd_row = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_wr_ready", s_wr, 1'b0);
      if (i > 0) chk("rst_rsp_valid", s_rv, 1'b0);
    end
    rst = 1'b0;

    // Bring every row to a known value through the controller.
    wr_data = '0;
    for (int r = 0; r < NROWS; r++) begin
      wr_row = r[RW-1:0];
      step();
    end
    wr_valid = 1'b0;
    step();
    chk_dat("rst_rsp_data", s_dat, '0);

    // Basic write / read with latency.
    wr_valid = 1'b1; wr_row = 5; wr_data = pat_a5; wr_strb = '1;
    step();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_row = 5; rsp_ready = 1'b1;
    step();
    chk("basic_rd_ready", s_rd, 1'b1);
    rd_valid = 1'b0;
    step();
    chk("basic_lat_t1", s_rv, 1'b0);
    step();
    chk("basic_lat_t2", s_rv, 1'b1);
    chk_dat("basic_data", s_dat, pat_a5);

    // Partial strobe merge.
    wr_valid = 1'b1; wr_row = 3; wr_data = {LB{8'h11}}; wr_strb = '1;
    step();
    wr_data = '1; wr_strb = 'hF;
    step();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_row = 3;
    step();
    rd_valid = 1'b0;
    step();
    step();
    chk("part_rsp_valid", s_rv, 1'b1);
    chk_dat("part_data", s_dat, pat_part);

    // Table: contention and backpressure straight out of reset.
    rst = 1'b1;
    step();
    rst = 1'b0; wr_strb = '1;
    prev_rv = 1'b0; prev_rr = 1'b1; prev_dat = '0;
    foreach (tbl[i]) begin
      wr_valid  = tbl[i].wv;
      rd_valid  = tbl[i].rv;
      rsp_ready = tbl[i].rr;
      wr_row    = RW'(8 + (i % 8));
      wr_data   = rand_line();
      rd_row    = (i % 2) ? RW'(5) : RW'(3);
      step();
      chk("tbl_wr_ready", s_wr, tbl[i].e_wr);
      chk("tbl_rd_ready", s_rd, tbl[i].e_rd);
      chk("tbl_rsp_valid", s_rv, tbl[i].e_rv);
      if (tbl[i].e_rv && prev_rv && !prev_rr) chk_dat("tbl_rsp_stable", s_dat, prev_dat);
      prev_rv = s_rv; prev_rr = tbl[i].rr; prev_dat = s_dat;
    end

    // Reset in the cycle after a read handshake discards the read.
    wr_valid = 1'b0; rd_valid = 1'b1; rd_row = 5; rsp_ready = 1'b1;
    step();
    chk("mid_rd_ready", s_rd, 1'b1);
    rd_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("mid_rsp_valid0", s_rv, 1'b0);
    step();
    chk("mid_rsp_valid1", s_rv, 1'b0);
    rd_valid = 1'b1; rd_row = 3;
    step();
    rd_valid = 1'b0;
    step();
    step();
    chk("mid_after_valid", s_rv, 1'b1);
    chk_dat("mid_after_data", s_dat, pat_part);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      wr_valid  = ($urandom_range(0, 99) < 50);
      rd_valid  = ($urandom_range(0, 99) < 70);
      rsp_ready = ($urandom_range(0, 99) < 60);
      wr_row    = RW'($urandom_range(0, 7));
      rd_row    = RW'($urandom_range(0, 7));
      wr_data   = rand_line();
      case ($urandom_range(0, 7))
        0:       wr_strb = '0;
        1:       wr_strb = '1;
        default: wr_strb = rand_strb();
      endcase
      step();
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mem_bank_ctrl.md
Name: mem_bank_ctrl

Overview:
- Single-port access controller in front of one mem_bank instance.
- Shares the bank between one write requester and one read requester using valid/ready handshakes.
- Arbitration is round-robin.
- Converts the bank's fixed 1-cycle registered read into a backpressured response channel with a holding register.
- Sits between the AXI channel front-ends and the storage bank.

Parameters:
- SIZE, 7, log2 of bank line width in bytes; line = 2**SIZE bytes; row address width RW = 12-SIZE.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted this cycle.
- wr_row  in  RW  write row address.
- wr_data  in  2**SIZE x 8  write line data.
- wr_strb  in  2**SIZE  per-byte write enables.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted this cycle.
- rd_row  in  RW  read row address.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  read response consumed.
- rsp_data  out  2**SIZE x 8  read response line.
- bank_we  out  1  to mem_bank we.
- bank_row  out  RW  to mem_bank row_addr.
- bank_wdata  out  2**SIZE x 8  to mem_bank wdata.
- bank_wstrb  out  2**SIZE  to mem_bank wstrb.
- bank_rdata  in  2**SIZE x 8  from mem_bank rdata; holds the row addressed in the previous cycle.

Behaviour:
- State registers:
  - last_gnt: 0=write, 1=read; reset value 1, so a write wins first contention.
  - rd_inflight: reset 0.
  - rsp_valid: reset 0.
  - rsp_data: reset 0.
- Eligibility:
  - Write is eligible when wr_valid=1.
  - Read is eligible when rd_valid=1, rd_inflight=0, and (rsp_valid=0 or rsp_ready=1).
- Grant (combinational, one grant per cycle maximum):
  - Only one side eligible: that side is granted.
  - Both eligible: the side not equal to last_gnt is granted.
  - last_gnt updates to the granted side; it holds when nothing is granted.
- Ready outputs:
  - wr_ready = write granted; rd_ready = read granted.
  - Ready may depend on valid.
  - Both ready outputs are forced 0 while rst=1.
- Bank drive (combinational):
  - bank_we = write granted.
  - bank_wstrb = wr_strb when write granted, else all-zero. The bank writes on strobes alone, so wstrb must be zero on every non-write cycle, including reset.
  - bank_row = wr_row when write granted, else rd_row.
  - bank_wdata = wr_data at all times.
- Write timing:
  - Write accepted in cycle T is committed at the end of T.
  - A read granted in T+1 or later to the same row returns the new bytes.
  - A write with all-zero wr_strb is accepted and modifies nothing.
- Read timing:
  - Read accepted in cycle T sets rd_inflight for cycle T+1.
  - In T+1: rsp_data <= bank_rdata, rsp_valid <= 1, rd_inflight <= 0.
  - rsp_valid is therefore first high in T+2, i.e. 2-cycle handshake-to-response latency.
  - Maximum read throughput is 1 per 2 cycles.
- Response channel:
  - rsp_valid=1 and rsp_ready=1 clears rsp_valid at the next edge, unless a capture occurs in the same cycle; capture wins and rsp_valid stays 1 with new data.
  - While rsp_valid=1 and rsp_ready=0, rsp_data is stable and no new read is granted.
  - Writes continue to be granted during read backpressure.
- Reset:
  - rst during an in-flight read discards it; rsp_valid stays 0 after reset.
  - rst has no effect on bank contents.

Test Plan:
- Reset: rst=1 for 3 cycles with wr_valid=1, wr_strb all-ones -> wr_ready=0, bank_wstrb=0, rsp_valid=0 every cycle.
- Basic write/read (SIZE=7): write row 5, data all 0xA5, strb all-ones; then read row 5 -> rsp_valid rises 2 cycles after rd handshake, rsp_data = 128 x 0xA5.
- Partial strobe: write row 3 all 0x11 (full strb), then write all 0xFF with strb=0x...000F; read row 3 -> bytes 0-3 = 0xFF, bytes 4-127 = 0x11.
- Contention: wr_valid=rd_valid=1 continuously from reset release, rsp_ready=1 -> grants W,R,W,R,...; first rsp_valid in cycle 3.
- Backpressure: response pending with rsp_ready=0 and rd_valid=1 for 5 cycles -> rd_ready=0 and rsp_data stable throughout, wr_ready=1 each cycle wr_valid=1; raising rsp_ready -> read granted that same cycle.
- Reset mid-read: rst=1 in the cycle after a read handshake -> rsp_valid stays 0; next read after reset returns correct data.
